// File: rtl/mult_accumulator.sv
// Accumulates delayed multiplier products into dot-product results, saturating on
// overflow, and queues finished results in a 2-entry first-word-fall-through FIFO.
module mult_accumulator #(
    parameter int LATENCY = 5,
    parameter int ACC_W   = 40,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic             op_last,
    input  logic [31:0]      P,
    output logic [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0] res_count,
    output logic             res_sat,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             drop_err,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Delay line tracking which product cycles carry a valid pair
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] lst_q, lst_d;
    logic               dly_vld_s;
    logic               dly_lst_s;

    // Accumulator state
    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    // Arithmetic helpers
    logic [ACC_W-1:0]   acc_base_s;
    logic [CNT_W-1:0]   cnt_base_s;
    logic               sat_base_s;
    logic [ACC_W:0]     sum_ext_s;
    logic [ACC_W-1:0]   sum_sat_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               sat_inc_s;
    logic               push_s;

    // FIFO storage: entry 0 is always the head
    logic [ACC_W-1:0]   e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic [CNT_W-1:0]   e0_cnt_q, e0_cnt_d, e1_cnt_q, e1_cnt_d;
    logic               e0_sat_q, e0_sat_d, e1_sat_q, e1_sat_d;
    logic [1:0]         occ_q, occ_d;
    logic               valid_q, valid_d;
    logic               drop_q, drop_d;
    logic               busy_q, busy_d;
    logic               pop_s;
    logic               push_ok_s;
    logic               full_s;

    // Shift op_valid/op_last down the delay line; last is only meaningful with valid
    always_comb begin
        vld_d    = vld_q;
        lst_d    = lst_q;
        vld_d[0] = op_valid;
        lst_d[0] = op_valid & op_last;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
    end

    assign dly_vld_s = vld_q[LATENCY-1];
    assign dly_lst_s = lst_q[LATENCY-1];

    // Select the running totals the incoming product is added to
    always_comb begin
        acc_base_s = {ACC_W{1'b0}};
        cnt_base_s = {CNT_W{1'b0}};
        sat_base_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                acc_base_s = {ACC_W{1'b0}};
                cnt_base_s = {CNT_W{1'b0}};
                sat_base_s = 1'b0;
            end
            ST_RUN: begin
                acc_base_s = acc_q;
                cnt_base_s = cnt_q;
                sat_base_s = sat_q;
            end
            default: begin
                acc_base_s = {ACC_W{1'b0}};
                cnt_base_s = {CNT_W{1'b0}};
                sat_base_s = 1'b0;
            end
        endcase
    end

    // Saturating add of the zero-extended product and saturating term count
    always_comb begin
        sum_ext_s = {1'b0, acc_base_s} + {{(ACC_W-31){1'b0}}, P};
        if (sum_ext_s[ACC_W]) begin
            sum_sat_s = {ACC_W{1'b1}};
        end else begin
            sum_sat_s = sum_ext_s[ACC_W-1:0];
        end
        if (cnt_base_s == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_base_s;
        end else begin
            cnt_inc_s = cnt_base_s + CNT_W'(1);
        end
        sat_inc_s = sat_base_s | sum_ext_s[ACC_W];
    end

    // Accumulator FSM: a delayed last pushes the completed result and returns to IDLE
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        push_s  = 1'b0;
        if (dly_vld_s) begin
            if (dly_lst_s) begin
                push_s  = 1'b1;
                acc_d   = {ACC_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                sat_d   = 1'b0;
                state_d = ST_IDLE;
            end else begin
                acc_d   = sum_sat_s;
                cnt_d   = cnt_inc_s;
                sat_d   = sat_inc_s;
                state_d = ST_RUN;
            end
        end else begin
            state_d = state_q;
        end
    end

    assign pop_s     = valid_q & res_ready;
    assign full_s    = (occ_q == 2'd2);
    assign push_ok_s = push_s & (~full_s | pop_s);

    // FIFO update; a push into a full FIFO without a pop is dropped and flagged
    always_comb begin
        e0_data_d = e0_data_q;
        e0_cnt_d  = e0_cnt_q;
        e0_sat_d  = e0_sat_q;
        e1_data_d = e1_data_q;
        e1_cnt_d  = e1_cnt_q;
        e1_sat_d  = e1_sat_q;
        occ_d     = occ_q;
        drop_d    = drop_q | (push_s & full_s & ~pop_s);
        case (occ_q)
            2'd0: begin
                if (push_ok_s) begin
                    e0_data_d = sum_sat_s;
                    e0_cnt_d  = cnt_inc_s;
                    e0_sat_d  = sat_inc_s;
                    occ_d     = 2'd1;
                end else begin
                    occ_d = 2'd0;
                end
            end
            2'd1: begin
                if (push_ok_s && pop_s) begin
                    e0_data_d = sum_sat_s;
                    e0_cnt_d  = cnt_inc_s;
                    e0_sat_d  = sat_inc_s;
                end else if (push_ok_s) begin
                    e1_data_d = sum_sat_s;
                    e1_cnt_d  = cnt_inc_s;
                    e1_sat_d  = sat_inc_s;
                    occ_d     = 2'd2;
                end else if (pop_s) begin
                    occ_d = 2'd0;
                end else begin
                    occ_d = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    e0_data_d = e1_data_q;
                    e0_cnt_d  = e1_cnt_q;
                    e0_sat_d  = e1_sat_q;
                    if (push_ok_s) begin
                        e1_data_d = sum_sat_s;
                        e1_cnt_d  = cnt_inc_s;
                        e1_sat_d  = sat_inc_s;
                    end else begin
                        occ_d = 2'd1;
                    end
                end else begin
                    occ_d = 2'd2;
                end
            end
            default: begin
                occ_d = 2'd0;
            end
        endcase
        valid_d = (occ_d != 2'd0);
        busy_d  = (|vld_d) | (state_d == ST_RUN);
    end

    // All state registers share the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= {LATENCY{1'b0}};
            lst_q     <= {LATENCY{1'b0}};
            state_q   <= ST_IDLE;
            acc_q     <= {ACC_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            sat_q     <= 1'b0;
            e0_data_q <= {ACC_W{1'b0}};
            e0_cnt_q  <= {CNT_W{1'b0}};
            e0_sat_q  <= 1'b0;
            e1_data_q <= {ACC_W{1'b0}};
            e1_cnt_q  <= {CNT_W{1'b0}};
            e1_sat_q  <= 1'b0;
            occ_q     <= 2'd0;
            valid_q   <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            lst_q     <= lst_d;
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            e0_data_q <= e0_data_d;
            e0_cnt_q  <= e0_cnt_d;
            e0_sat_q  <= e0_sat_d;
            e1_data_q <= e1_data_d;
            e1_cnt_q  <= e1_cnt_d;
            e1_sat_q  <= e1_sat_d;
            occ_q     <= occ_d;
            valid_q   <= valid_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
        end
    end

    assign res_data  = e0_data_q;
    assign res_count = e0_cnt_q;
    assign res_sat   = e0_sat_q;
    assign res_valid = valid_q;
    assign drop_err  = drop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Self-checking bench: models the multiplier pipeline and checks results against a
// transaction-level dot-product/FIFO model.
module tb_mult_accumulator;

    localparam int LAT  = 5;
    localparam int AW   = 40;
    localparam int CW   = 8;
    localparam int AW33 = 33;

    logic            clk;
    logic            rst_n;
    logic            op_valid;
    logic            op_last;
    logic [31:0]     P;
    logic            res_ready;
    logic [AW-1:0]   res_data;
    logic [CW-1:0]   res_count;
    logic            res_sat;
    logic            res_valid;
    logic            drop_err;
    logic            busy;
    logic [AW33-1:0] r33_data;
    logic [CW-1:0]   r33_count;
    logic            r33_sat;
    logic            r33_valid;
    logic            r33_drop;
    logic            r33_busy;

    mult_accumulator #(.LATENCY(LAT), .ACC_W(AW), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_last(op_last), .P(P),
        .res_data(res_data), .res_count(res_count), .res_sat(res_sat),
        .res_valid(res_valid), .res_ready(res_ready), .drop_err(drop_err), .busy(busy)
    );

    mult_accumulator #(.LATENCY(LAT), .ACC_W(AW33), .CNT_W(CW)) u_dut33 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_last(op_last), .P(P),
        .res_data(r33_data), .res_count(r33_count), .res_sat(r33_sat),
        .res_valid(r33_valid), .res_ready(res_ready), .drop_err(r33_drop), .busy(r33_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit v; bit l; logic [31:0] prod; } op_t;
    typedef struct { logic [63:0] data; int cnt; bit sat; } res_t;

    op_t         hist[$];
    res_t        mfifo[$];
    logic [63:0] m_sum;
    int          m_n;
    bit          m_drop;
    int          passed;
    int          total;

    function automatic bit m_busy();
        bit b;
        b = (m_n > 0);
        foreach (hist[i]) b = b | hist[i].v;
        return b;
    endfunction

    // One clock: present a pair, play the multiplier, update the model after the edge
    task automatic step(input bit v, input bit l, input logic [15:0] a, input logic [15:0] b,
                        input bit rdy);
        op_t         o;
        op_t         c;
        bit          have_c;
        bit          pop;
        bit          full;
        bit          push_req;
        res_t        r;
        logic [63:0] maxv;
        o.v    = v;
        o.l    = v & l;
        o.prod = {16'd0, a} * {16'd0, b};
        hist.push_back(o);
        have_c = 1'b0;
        c      = o;
        if (hist.size() > LAT) begin
            c      = hist.pop_front();
            have_c = 1'b1;
        end
        P         = (have_c && c.v) ? c.prod : $urandom();
        op_valid  = v;
        op_last   = l;
        res_ready = rdy;
        @(posedge clk);
        maxv     = (64'd1 << AW) - 64'd1;
        pop      = (mfifo.size() > 0) && rdy;
        full     = (mfifo.size() == 2);
        push_req = 1'b0;
        r.data   = 64'd0;
        r.cnt    = 0;
        r.sat    = 1'b0;
        if (have_c && c.v) begin
            m_sum = m_sum + {32'd0, c.prod};
            m_n   = m_n + 1;
            if (c.l) begin
                r.data   = (m_sum > maxv) ? maxv : m_sum;
                r.sat    = (m_sum > maxv);
                r.cnt    = (m_n > 255) ? 255 : m_n;
                m_sum    = 64'd0;
                m_n      = 0;
                push_req = 1'b1;
            end
        end
        if (pop) void'(mfifo.pop_front());
        if (push_req) begin
            if (!full || pop) mfifo.push_back(r);
            else m_drop = 1'b1;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_last   = 1'b0;
        res_ready = 1'b0;
        hist.delete();
        mfifo.delete();
        m_sum  = 64'd0;
        m_n    = 0;
        m_drop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        op_valid = 1'b0;
        op_last = 1'b0;
        res_ready = 1'b0;
        P = 32'd0;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (res_valid !== 1'b0 || drop_err !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_flags: got valid=%b drop=%b busy=%b expected 0 0 0", res_valid, drop_err, busy);
        end else passed++;
        total++;
        if (res_data !== '0 || res_count !== '0 || res_sat !== 1'b0) begin
            $display("FAIL reset_data: got data=%0h cnt=%0d sat=%b expected 0 0 0", res_data, res_count, res_sat);
        end else passed++;
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            if (k == 0) step(1'b1, 1'b0, 16'd3, 16'd4, 1'b1);
            else if (k == 1) step(1'b1, 1'b1, 16'd5, 16'd6, 1'b1);
            else step(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
            total++;
            if (res_valid !== (k == 6)) begin
                $display("FAIL basic_valid_k%0d: got %b expected %b", k, res_valid, (k == 6));
            end else passed++;
            if (k == 6) begin
                total++;
                if (res_data !== AW'(42) || res_count !== CW'(2) || res_sat !== 1'b0) begin
                    $display("FAIL basic_result: got %0d/%0d/%b expected 42/2/0", res_data, res_count, res_sat);
                end else passed++;
            end
        end
    endtask

    task automatic test_single();
        int seen;
        apply_reset();
        seen = 0;
        step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
            if (res_valid === 1'b1) begin
                seen++;
                total++;
                if (res_data !== AW'(32'hFFFE0001) || res_count !== CW'(1)) begin
                    $display("FAIL single_result: got %0h/%0d expected fffe0001/1", res_data, res_count);
                end else passed++;
            end
        end
        total++;
        if (seen !== 1) $display("FAIL single_valid_cycles: got %0d expected 1", seen);
        else passed++;
    endtask

    task automatic test_saturation();
        bit seen;
        apply_reset();
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k < 3) step(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
            else if (k == 3) step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
            else step(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
            if (mfifo.size() > 0) begin
                seen = 1'b1;
                total++;
                if (r33_valid !== 1'b1 || r33_data !== 33'h1FFFFFFFF || r33_sat !== 1'b1 || r33_count !== CW'(4)) begin
                    $display("FAIL sat33_result: got v=%b %0h/%0d/%b expected 1 1ffffffff/4/1", r33_valid, r33_data, r33_count, r33_sat);
                end else passed++;
                total++;
                if (res_data !== mfifo[0].data[AW-1:0] || res_sat !== mfifo[0].sat) begin
                    $display("FAIL sat40_result: got %0h/%b expected %0h/%b", res_data, res_sat, mfifo[0].data[AW-1:0], mfifo[0].sat);
                end else passed++;
            end
        end
        total++;
        if (!seen) $display("FAIL sat_seen: got 0 results expected 1");
        else passed++;
    endtask

    task automatic test_drop();
        apply_reset();
        step(1'b1, 1'b1, 16'd7, 16'd1, 1'b0);
        step(1'b1, 1'b1, 16'd8, 16'd1, 1'b0);
        step(1'b1, 1'b1, 16'd9, 16'd1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        total++;
        if (drop_err !== 1'b1 || res_valid !== 1'b1 || res_data !== AW'(7)) begin
            $display("FAIL drop_full: got drop=%b valid=%b data=%0d expected 1 1 7", drop_err, res_valid, res_data);
        end else passed++;
        step(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        total++;
        if (res_valid !== 1'b1 || res_data !== AW'(8)) begin
            $display("FAIL drop_pop1: got valid=%b data=%0d expected 1 8", res_valid, res_data);
        end else passed++;
        step(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        total++;
        if (res_valid !== 1'b0 || drop_err !== 1'b1) begin
            $display("FAIL drop_pop2: got valid=%b drop=%b expected 0 1", res_valid, drop_err);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        int seen;
        apply_reset();
        seen = 0;
        step(1'b1, 1'b0, 16'd1, 16'd1, 1'b1);
        step(1'b1, 1'b0, 16'd2, 16'd2, 1'b1);
        apply_reset();
        step(1'b1, 1'b0, 16'd2, 16'd2, 1'b1);
        step(1'b1, 1'b1, 16'd3, 16'd3, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
            if (res_valid === 1'b1) begin
                seen++;
                total++;
                if (res_data !== AW'(13) || res_count !== CW'(2)) begin
                    $display("FAIL midreset_result: got %0d/%0d expected 13/2", res_data, res_count);
                end else passed++;
            end
        end
        total++;
        if (seen !== 1) $display("FAIL midreset_count: got %0d results expected 1", seen);
        else passed++;
    endtask

    task automatic test_gaps();
        int seen;
        apply_reset();
        seen = 0;
        step(1'b1, 1'b0, 16'd1, 16'd1, 1'b1);
        step(1'b0, 1'b1, 16'hBEEF, 16'h1234, 1'b1);
        step(1'b0, 1'b1, 16'h5A5A, 16'hFFFF, 1'b1);
        step(1'b1, 1'b1, 16'd2, 16'd2, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
            if (res_valid === 1'b1) begin
                seen++;
                total++;
                if (res_data !== AW'(5) || res_count !== CW'(2)) begin
                    $display("FAIL gaps_result: got %0d/%0d expected 5/2", res_data, res_count);
                end else passed++;
            end
        end
        total++;
        if (seen !== 1) $display("FAIL gaps_count: got %0d results expected 1", seen);
        else passed++;
    endtask

    task automatic test_count_sat();
        apply_reset();
        for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 16'd2, 16'd3, 1'b1);
        step(1'b1, 1'b1, 16'd1, 16'd1, 1'b1);
        repeat (LAT) step(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        total++;
        if (res_valid !== 1'b1 || res_count !== CW'(255) || res_data !== AW'(1801)) begin
            $display("FAIL cnt_sat: got v=%b cnt=%0d data=%0d expected 1 255 1801", res_valid, res_count, res_data);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        bit          v;
        bit          l;
        bit          rdy;
        logic [15:0] a;
        logic [15:0] b;
        int          bad;
        apply_reset();
        bad = 0;
        for (int k = 0; k < 420; k++) begin
            if (k < 400) begin
                v   = ($urandom_range(0, 3) != 0);
                l   = ($urandom_range(0, 2) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                a   = 16'($urandom());
                b   = 16'($urandom());
            end else begin
                v = 1'b0; l = 1'b0; rdy = 1'b1; a = 16'd0; b = 16'd0;
            end
            step(v, l, a, b, rdy);
            total++;
            if (res_valid !== (mfifo.size() > 0) || drop_err !== m_drop || busy !== m_busy()) begin
                $display("FAIL rand_flags_k%0d: got v=%b d=%b b=%b expected %b %b %b", k, res_valid, drop_err, busy,
                         (mfifo.size() > 0), m_drop, m_busy());
                bad++;
            end else passed++;
            if (mfifo.size() > 0) begin
                total++;
                if (res_data !== mfifo[0].data[AW-1:0] || res_count !== CW'(mfifo[0].cnt) || res_sat !== mfifo[0].sat) begin
                    $display("FAIL rand_head_k%0d: got %0h/%0d/%b expected %0h/%0d/%b", k, res_data, res_count, res_sat,
                             mfifo[0].data[AW-1:0], mfifo[0].cnt, mfifo[0].sat);
                    bad++;
                end else passed++;
            end
            if (bad > 10) break;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        m_sum  = 64'd0;
        m_n    = 0;
        m_drop = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_saturation();
        test_drop();
        test_reset_mid();
        test_gaps();
        test_count_sat();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 The block SHALL have parameter LATENCY, default 5, meaning cycles from operands sampled at the multiplier to product sampled here.
REQ-002 The block SHALL have parameter ACC_W, default 40, meaning accumulator and result width.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning term-counter width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port op_valid, input, 1, high when a valid A/B pair is presented to the multiplier this cycle.
REQ-007 The block SHALL have port op_last, input, 1, qualified by op_valid; marks the final pair of a dot product.
REQ-008 The block SHALL have port P, input, 32, the multiplier product, unsigned.
REQ-009 The block SHALL have port res_data, output, ACC_W, the head-of-FIFO accumulated result.
REQ-010 The block SHALL have port res_count, output, CNT_W, the number of terms in the head result.
REQ-011 The block SHALL have port res_sat, output, 1, set when the head result saturated.
REQ-012 The block SHALL have port res_valid, output, 1, high when the FIFO is non-empty.
REQ-013 The block SHALL have port res_ready, input, 1, consumer accept.
REQ-014 The block SHALL have port drop_err, output, 1, sticky flag for a result lost to a full FIFO.
REQ-015 The block SHALL have port busy, output, 1, high when any tracked operand is in flight or the accumulator is in RUN.

Function
REQ-016 Delay line: op_valid and op_last SHALL pass through a LATENCY-stage register line; op_last SHALL be gated by op_valid at entry.
REQ-017 Alignment: a pair with op_valid sampled at edge N SHALL have its P consumed at edge N+LATENCY.
REQ-018 P SHALL be ignored in every cycle where the delayed valid is low.
REQ-019 Accumulator FSM SHALL have two states, IDLE (acc=0, cnt=0) and RUN.
REQ-020 From IDLE, a delayed valid without last SHALL load acc=P and cnt=1, then go to RUN.
REQ-021 In RUN, a delayed valid without last SHALL set acc=acc+P and cnt=cnt+1, staying in RUN.
REQ-022 In either state, a delayed valid with last SHALL push {acc+P (or P from IDLE), cnt+1, sat} into the FIFO, clear acc, cnt and sat, and go to IDLE.
REQ-023 Arithmetic: P SHALL be zero-extended to ACC_W before addition.
REQ-024 On carry out of ACC_W, the sum SHALL saturate to all-ones and the sat flag SHALL be set until the push.
REQ-025 cnt SHALL saturate at all-ones with no wrap.
REQ-026 Output FIFO: depth 2, first-word-fall-through; res_* SHALL reflect the head entry.
REQ-027 Handshake: a pop SHALL occur at an edge where res_valid and res_ready are both high; res_data, res_count and res_sat SHALL hold stable while res_valid is high and res_ready is low.
REQ-028 Simultaneous push and pop SHALL be allowed at any occupancy, including full (occupancy unchanged) and empty (the push sets res_valid next cycle).
REQ-029 A push while full with no pop SHALL discard the new result and set drop_err; the FIFO contents SHALL be unchanged.
REQ-030 drop_err SHALL clear only on reset.
REQ-031 The block SHALL never stall upstream; it has no backpressure path to the multiplier.
REQ-032 res_valid SHALL be 0 whenever the FIFO is empty; res_data is then don't-care.

Reset
REQ-033 On rst_n low, asynchronously: delay line cleared, FSM in IDLE, acc, cnt and sat = 0, FIFO empty, res_valid=0, res_data=0, res_count=0, res_sat=0, drop_err=0, busy=0.
REQ-034 Reset mid-operation SHALL discard in-flight operands and the partial sum; the first op_valid after release starts a fresh result.
REQ-035 Reset release SHALL take effect at the first rising edge with rst_n high.

Verification
REQ-036 Pairs (3,4),(5,6 last) on consecutive cycles from edge N, res_ready=1 -> res_valid rises after edge N+6; res_data=42, res_count=2, res_sat=0.
REQ-037 A single pair (0xFFFF,0xFFFF) with last -> res_data=0xFFFE0001, res_count=1, one cycle of res_valid.
REQ-038 With ACC_W=33, three last-free pairs of 0xFFFF^2 then a last pair of 0xFFFF^2 -> res_data=0x1FFFFFFFF, res_sat=1, res_count=4.
REQ-039 With res_ready=0, three single-term last results 7, 8, 9 -> FIFO holds 7,8 and drop_err=1; then res_ready=1 -> pops 7 then 8, and res_valid falls.
REQ-040 rst_n pulsed low between the 2nd and 3rd term of a 4-term product, then a fresh 2-term product (2,2),(3,3 last) -> single result 13, count 2, no stale output.
REQ-041 op_valid gaps: pairs (1,1), idle, idle, (2,2 last), with P driven to garbage during gaps -> result 5, count 2.
